// File: rtl/bless_inject_ctrl.sv
// bless_inject_ctrl
//   Local-node injection/ejection controller for port 4 of the bufferless,
//   age-based 5-port router. Core flits are queued and stamped with
//   {valid, dest, src=NODE_ID, age}. The head flit is then offered to the
//   router through registered outputs. Waiting flits age every cycle, and
//   a head that stays blocked too long raises starve. Ejected flits are
//   captured into a small FIFO for the core.
//
// Ports
//   i_clk, i_rst                 clock (rising edge), async active-low reset
//   i_core_valid/o_core_ready    core injection handshake
//   i_core_dest, i_core_data     destination id and payload of the core flit
//   i_port4_ready                router accepts the offered flit this cycle
//   o_inj_ci, o_inj_di           registered control/data to router port 4
//   i_ej_co, i_ej_do             ejected control/data from router port 4
//   o_ej_valid/i_ej_ready        core ejection handshake
//   o_ej_ctrl, o_ej_data         head of the ejection FIFO (zero when empty)
//   o_starve                     head blocked for >= STARVE_TH cycles
//   o_ej_drop_cnt                ejected flits lost to a full FIFO (saturating)

module bless_inject_ctrl #(
    parameter logic [7:0] NODE_ID   = 8'd0,
    parameter int         INJ_DEPTH = 4,
    parameter int         EJ_DEPTH  = 4,
    parameter int         STARVE_TH = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_core_valid,
    output logic         o_core_ready,
    input  logic [7:0]   i_core_dest,
    input  logic [127:0] i_core_data,
    input  logic         i_port4_ready,
    output logic [27:0]  o_inj_ci,
    output logic [127:0] o_inj_di,
    input  logic [27:0]  i_ej_co,
    input  logic [127:0] i_ej_do,
    output logic         o_ej_valid,
    input  logic         i_ej_ready,
    output logic [27:0]  o_ej_ctrl,
    output logic [127:0] o_ej_data,
    output logic         o_starve,
    output logic [15:0]  o_ej_drop_cnt
);

    localparam int           IAW     = $clog2(INJ_DEPTH);
    localparam int           EAW     = $clog2(EJ_DEPTH);
    localparam logic [IAW:0] INJ_ONE = (IAW+1)'(1);
    localparam logic [EAW:0] EJ_ONE  = (EAW+1)'(1);
    localparam logic [15:0]  WAIT_TH = 16'(STARVE_TH);
    localparam logic [10:0]  AGE_MAX = 11'h7FF;

    typedef struct packed {
        logic        vld;
        logic [7:0]  dest;
        logic [7:0]  src;
        logic [10:0] age;
    } ctrl_t;

    typedef enum logic {S_IDLE, S_OFFER} state_t;

    function automatic logic [10:0] age_inc(input logic [10:0] a);
        return (a == AGE_MAX) ? a : a + 11'd1;
    endfunction

    // ---------------------------------------------------------------
    // Injection FIFO
    // ---------------------------------------------------------------
    logic [7:0]     r_inj_dest [INJ_DEPTH];
    logic [127:0]   r_inj_data [INJ_DEPTH];
    logic [10:0]    r_inj_age  [INJ_DEPTH];
    logic [IAW:0]   r_inj_wr, r_inj_rd;
    state_t         r_state;
    ctrl_t          r_inj_ci;
    logic [127:0]   r_inj_di;
    logic [15:0]    r_wait;

    logic [IAW:0]   w_inj_cnt;
    logic           w_inj_empty, w_inj_full;
    logic           w_inj_push, w_inj_pop, w_inj_more;
    logic [IAW-1:0] w_hd_nxt;
    ctrl_t          w_nxt_ci;

    assign w_inj_cnt   = r_inj_wr - r_inj_rd;
    assign w_inj_empty = (r_inj_wr == r_inj_rd);
    assign w_inj_full  = (r_inj_wr[IAW] != r_inj_rd[IAW]) &&
                         (r_inj_wr[IAW-1:0] == r_inj_rd[IAW-1:0]);
    // core_ready comes from registered pointers, so a pop frees a slot
    // for the core only on the following cycle.
    assign w_inj_push  = i_core_valid && !w_inj_full;
    // OFFER is only ever held with a non-empty FIFO.
    assign w_inj_pop   = (r_state == S_OFFER) && i_port4_ready;
    assign w_inj_more  = (w_inj_cnt > INJ_ONE);

    // Entry that will be at the head after this edge; its age after this
    // edge is what the registered control word must carry.
    assign w_hd_nxt      = r_inj_rd[IAW-1:0] + IAW'(w_inj_pop);
    assign w_nxt_ci.vld  = 1'b1;
    assign w_nxt_ci.dest = r_inj_dest[w_hd_nxt];
    assign w_nxt_ci.src  = NODE_ID;
    assign w_nxt_ci.age  = age_inc(r_inj_age[w_hd_nxt]);

    always_ff @(posedge i_clk) begin
        if (w_inj_push) begin
            r_inj_dest[r_inj_wr[IAW-1:0]] <= i_core_dest;
            r_inj_data[r_inj_wr[IAW-1:0]] <= i_core_data;
        end
    end

    // Every slot ages each cycle; a push restarts its slot at zero. Ages of
    // free slots are meaningless but saturate harmlessly.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < INJ_DEPTH; i++) r_inj_age[i] <= '0;
        end else begin
            for (int i = 0; i < INJ_DEPTH; i++) begin
                if (w_inj_push && (r_inj_wr[IAW-1:0] == IAW'(i)))
                    r_inj_age[i] <= '0;
                else
                    r_inj_age[i] <= age_inc(r_inj_age[i]);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_inj_wr <= '0;
            r_inj_rd <= '0;
        end else begin
            if (w_inj_push) r_inj_wr <= r_inj_wr + INJ_ONE;
            if (w_inj_pop)  r_inj_rd <= r_inj_rd + INJ_ONE;
        end
    end

    // Injection FSM with registered router-facing outputs.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state  <= S_IDLE;
            r_inj_ci <= '0;
            r_inj_di <= '0;
            r_wait   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wait <= '0;
                    if (!w_inj_empty) begin
                        r_state  <= S_OFFER;
                        r_inj_ci <= w_nxt_ci;
                        r_inj_di <= r_inj_data[w_hd_nxt];
                    end else begin
                        r_inj_ci <= '0;
                        r_inj_di <= '0;
                    end
                end
                S_OFFER: begin
                    if (i_port4_ready) begin
                        r_wait <= '0;
                        if (w_inj_more) begin
                            r_inj_ci <= w_nxt_ci;
                            r_inj_di <= r_inj_data[w_hd_nxt];
                        end else begin
                            r_state  <= S_IDLE;
                            r_inj_ci <= '0;
                            r_inj_di <= '0;
                        end
                    end else begin
                        // Hold the same flit, refreshed with its new age.
                        if (r_wait != 16'hFFFF) r_wait <= r_wait + 16'd1;
                        r_inj_ci <= w_nxt_ci;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_core_ready = !w_inj_full;
    assign o_inj_ci     = r_inj_ci;
    assign o_inj_di     = r_inj_di;
    assign o_starve     = (r_wait >= WAIT_TH);

    // ---------------------------------------------------------------
    // Ejection FIFO
    // ---------------------------------------------------------------
    logic [27:0]  r_ej_ctrl [EJ_DEPTH];
    logic [127:0] r_ej_data [EJ_DEPTH];
    logic [EAW:0] r_ej_wr, r_ej_rd;
    logic [15:0]  r_drop;

    logic w_ej_empty, w_ej_full, w_ej_pop, w_ej_push, w_ej_drop;

    assign w_ej_empty = (r_ej_wr == r_ej_rd);
    assign w_ej_full  = (r_ej_wr[EAW] != r_ej_rd[EAW]) &&
                        (r_ej_wr[EAW-1:0] == r_ej_rd[EAW-1:0]);
    assign w_ej_pop   = !w_ej_empty && i_ej_ready;
    // A same-cycle pop makes room, so a full FIFO still accepts the flit.
    assign w_ej_push  = i_ej_co[27] && (!w_ej_full || w_ej_pop);
    assign w_ej_drop  = i_ej_co[27] && w_ej_full && !w_ej_pop;

    always_ff @(posedge i_clk) begin
        if (w_ej_push) begin
            r_ej_ctrl[r_ej_wr[EAW-1:0]] <= i_ej_co;
            r_ej_data[r_ej_wr[EAW-1:0]] <= i_ej_do;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ej_wr <= '0;
            r_ej_rd <= '0;
            r_drop  <= '0;
        end else begin
            if (w_ej_push) r_ej_wr <= r_ej_wr + EJ_ONE;
            if (w_ej_pop)  r_ej_rd <= r_ej_rd + EJ_ONE;
            if (w_ej_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
        end
    end

    assign o_ej_valid    = !w_ej_empty;
    assign o_ej_ctrl     = w_ej_empty ? 28'h0   : r_ej_ctrl[r_ej_rd[EAW-1:0]];
    assign o_ej_data     = w_ej_empty ? 128'h0  : r_ej_data[r_ej_rd[EAW-1:0]];
    assign o_ej_drop_cnt = r_drop;

endmodule

// File: tb/tb_bless_inject_ctrl.sv
// Directed bench for bless_inject_ctrl: a table of ejection vectors plus
// hand-written injection, starvation, age-saturation and reset sequences.
module tb_bless_inject_ctrl;

    localparam logic [7:0] NID = 8'h3C;

    logic         clk = 1'b0;
    logic         rst;
    logic         core_valid, core_ready;
    logic [7:0]   core_dest;
    logic [127:0] core_data;
    logic         port4_ready;
    logic [27:0]  inj_ci;
    logic [127:0] inj_di;
    logic [27:0]  ej_co;
    logic [127:0] ej_do;
    logic         ej_valid, ej_ready;
    logic [27:0]  ej_ctrl;
    logic [127:0] ej_data;
    logic         starve;
    logic [15:0]  ej_drop_cnt;

    int n_vec = 0;
    int n_mis = 0;

    bless_inject_ctrl #(
        .NODE_ID(NID), .INJ_DEPTH(4), .EJ_DEPTH(4), .STARVE_TH(16)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_core_valid(core_valid), .o_core_ready(core_ready),
        .i_core_dest(core_dest), .i_core_data(core_data),
        .i_port4_ready(port4_ready),
        .o_inj_ci(inj_ci), .o_inj_di(inj_di),
        .i_ej_co(ej_co), .i_ej_do(ej_do),
        .o_ej_valid(ej_valid), .i_ej_ready(ej_ready),
        .o_ej_ctrl(ej_ctrl), .o_ej_data(ej_data),
        .o_starve(starve), .o_ej_drop_cnt(ej_drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [27:0] mk_ci(input logic [7:0] d, input logic [10:0] a);
        return {1'b1, d, NID, a};
    endfunction

    typedef struct {
        logic       ev;    // drive ej_co[27]
        logic [7:0] tag;   // identifies the ejected flit
        logic       rdy;   // ej_ready
        logic       xv;    // expected ej_valid after the edge
        logic [7:0] xtag;  // expected head tag after the edge
        logic [15:0] xdrop;
    } ej_vec_t;

    ej_vec_t tbl [13];

    initial begin
        // ejection vectors: fill to 4, one drop, full+pop+push, drain
        tbl[0]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 8'hA1, 16'd0};
        tbl[1]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 8'hA1, 16'd0};
        tbl[2]  = '{1'b1, 8'hA3, 1'b0, 1'b1, 8'hA1, 16'd0};
        tbl[3]  = '{1'b1, 8'hA4, 1'b0, 1'b1, 8'hA1, 16'd0};
        tbl[4]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA1, 16'd1};
        tbl[5]  = '{1'b1, 8'hA6, 1'b1, 1'b1, 8'hA2, 16'd1};
        tbl[6]  = '{1'b0, 8'hB0, 1'b1, 1'b1, 8'hA3, 16'd1};
        tbl[7]  = '{1'b0, 8'hB1, 1'b1, 1'b1, 8'hA4, 16'd1};
        tbl[8]  = '{1'b0, 8'hB2, 1'b1, 1'b1, 8'hA6, 16'd1};
        tbl[9]  = '{1'b0, 8'hB3, 1'b1, 1'b0, 8'h00, 16'd1};
        tbl[10] = '{1'b1, 8'hA7, 1'b1, 1'b1, 8'hA7, 16'd1};
        tbl[11] = '{1'b0, 8'hB4, 1'b0, 1'b1, 8'hA7, 16'd1};
        tbl[12] = '{1'b0, 8'hB5, 1'b1, 1'b0, 8'h00, 16'd1};

        rst = 1'b0;
        core_valid = 0; core_dest = '0; core_data = '0;
        port4_ready = 0; ej_co = '0; ej_do = '0; ej_ready = 0;
        tick(); tick();

        // reset state
        chk("rst core_ready", core_ready, 1);
        chk("rst inj_ci", inj_ci, 0);
        chk("rst inj_di", inj_di, 0);
        chk("rst ej_valid", ej_valid, 0);
        chk("rst ej_ctrl", ej_ctrl, 0);
        chk("rst ej_data", ej_data, 0);
        chk("rst starve", starve, 0);
        chk("rst drop", ej_drop_cnt, 0);
        rst = 1'b1;
        tick();

        // single flit injection, router ready
        port4_ready = 1;
        core_valid = 1; core_dest = 8'h05; core_data = 128'd1;
        tick();
        core_valid = 0;
        chk("t1 push ready", core_ready, 1);
        chk("t1 ci idle", inj_ci, 0);
        tick();
        chk("t1 ci", inj_ci, mk_ci(8'h05, 11'd1));
        chk("t1 di", inj_di, 128'd1);
        chk("t1 ready", core_ready, 1);
        tick();
        chk("t1 ci after pop", inj_ci, 0);
        chk("t1 di after pop", inj_di, 0);

        // ejection table
        for (int i = 0; i < 13; i++) begin
            ej_co    = {tbl[i].ev, tbl[i].tag, 19'h0};
            ej_do    = {tbl[i].tag, 112'h0, tbl[i].tag};
            ej_ready = tbl[i].rdy;
            tick();
            chk($sformatf("ej[%0d] valid", i), ej_valid, tbl[i].xv);
            chk($sformatf("ej[%0d] ctrl", i), ej_ctrl,
                tbl[i].xv ? {1'b1, tbl[i].xtag, 19'h0} : 28'h0);
            chk($sformatf("ej[%0d] data", i), ej_data,
                tbl[i].xv ? {tbl[i].xtag, 112'h0, tbl[i].xtag} : 128'h0);
            chk($sformatf("ej[%0d] drop", i), ej_drop_cnt, tbl[i].xdrop);
        end
        ej_co = '0; ej_do = '0; ej_ready = 0;

        // fill 4 with router blocked, starve, then drain in order
        port4_ready = 0;
        for (int k = 0; k < 4; k++) begin
            core_valid = 1; core_dest = 8'h10 + 8'(k); core_data = 128'(100 + k);
            tick();
        end
        core_dest = 8'h99; core_data = 128'd999;   // keeps offering while full
        chk("t2 full ready", core_ready, 0);
        chk("t2 head ci", inj_ci, mk_ci(8'h10, 11'd3));
        repeat (13) tick();
        chk("t2 starve pre", starve, 0);
        tick();
        chk("t2 starve", starve, 1);
        chk("t2 head aged", inj_ci, mk_ci(8'h10, 11'd17));
        chk("t2 still full", core_ready, 0);
        core_valid = 0;
        port4_ready = 1;
        for (int k = 1; k < 4; k++) begin
            tick();
            chk($sformatf("t2 ci%0d", k), inj_ci, mk_ci(8'h10 + 8'(k), 11'd17));
            chk($sformatf("t2 di%0d", k), inj_di, 128'(100 + k));
            if (k == 1) begin
                chk("t2 starve clr", starve, 0);
                chk("t2 ready back", core_ready, 1);
            end
        end
        tick();
        chk("t2 drained ci", inj_ci, 0);
        tick();
        chk("t2 no extra", inj_ci, 0);

        // age saturation with head held
        port4_ready = 0;
        core_valid = 1; core_dest = 8'h22; core_data = 128'hABC;
        tick();
        core_valid = 0;
        tick();
        chk("t5 age1", inj_ci, mk_ci(8'h22, 11'd1));
        repeat (2045) tick();
        chk("t5 age7FE", inj_ci, mk_ci(8'h22, 11'h7FE));
        tick();
        chk("t5 age7FF", inj_ci, mk_ci(8'h22, 11'h7FF));
        repeat (60) tick();
        chk("t5 age sat", inj_ci, mk_ci(8'h22, 11'h7FF));
        chk("t5 di", inj_di, 128'hABC);
        chk("t5 starve", starve, 1);

        // load both FIFOs, then reset mid-operation
        for (int k = 0; k < 3; k++) begin
            core_valid = 1; core_dest = 8'h30 + 8'(k); core_data = 128'(k);
            ej_co = {1'b1, 8'hC0 + 8'(k), 19'h0}; ej_do = 128'(k);
            tick();
        end
        core_valid = 0; ej_co = '0; ej_do = '0;
        chk("t6 pre full", core_ready, 0);
        chk("t6 pre ejv", ej_valid, 1);
        chk("t6 pre ejc", ej_ctrl, {1'b1, 8'hC0, 19'h0});
        rst = 1'b0;
        #1;
        chk("t6 ci", inj_ci, 0);
        chk("t6 di", inj_di, 0);
        chk("t6 ready", core_ready, 1);
        chk("t6 ejv", ej_valid, 0);
        chk("t6 ejc", ej_ctrl, 0);
        chk("t6 starve", starve, 0);
        chk("t6 drop", ej_drop_cnt, 0);
        tick();
        rst = 1'b1;
        tick(); tick();
        chk("t6 post ci", inj_ci, 0);
        chk("t6 post ejv", ej_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
